led_pattern_gen: RTL

//   Multi-channel LED pattern generator for status and debug LEDs on the 50 MHz system clock.

---
 rtl/led_pattern_gen.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module  : led_pattern_gen
// Brief   : Multi-channel LED pattern generator (OFF/ON/BLINK/BURST) with a
//           shared tick prescaler, per-channel config port and heartbeat LED.
// Revision: 1.0 - initial release
// ============================================================================
module led_pattern_gen #(
  parameter int NUM_CH   = 4,
  parameter int PER_W    = 10,
  parameter int PRESC_W  = 16,
  parameter int PRESCALE = 50000,
  parameter int HB_W     = 26,
  parameter int HB_BIT   = 20,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_50,
  input  logic              resetn,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_addr,
  input  logic [PER_W-1:0]  cfg_wdata,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] burst_done,
  output logic              debug_led
);

  localparam logic [1:0] c_mode_off   = 2'd0;
  localparam logic [1:0] c_mode_on    = 2'd1;
  localparam logic [1:0] c_mode_burst = 2'd3;

  localparam logic [1:0] c_addr_mode   = 2'd0;
  localparam logic [1:0] c_addr_period = 2'd1;
  localparam logic [1:0] c_addr_duty   = 2'd2;

  localparam logic [PRESC_W-1:0] c_presc_last = PRESC_W'(PRESCALE - 1);
  localparam logic [CH_W:0]      c_num_ch     = (CH_W + 1)'(NUM_CH);
  localparam logic [PER_W-1:0]   c_one        = PER_W'(1);

  // Reset asserts asynchronously but is released two clocks later, in sync with clk_50.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk_50 or negedge resetn) begin
    if (!resetn) r_rst_sync <= 2'b00;
    else         r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  logic [PRESC_W-1:0] r_presc;
  logic [HB_W-1:0]    r_hb;
  logic               w_tick;
  logic               w_cfg_ok;

  assign w_tick   = (r_presc == c_presc_last);
  assign w_cfg_ok = cfg_we && ({1'b0, cfg_ch} < c_num_ch);

  always_ff @(posedge clk_50 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_presc <= '0;
      r_hb    <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
      r_hb    <= r_hb + HB_W'(1);
    end
  end

  assign debug_led = r_hb[HB_BIT];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [CH_W-1:0] c_idx = CH_W'(i);

    logic [1:0]       r_mode;
    logic [PER_W-1:0] r_period;
    logic [PER_W-1:0] r_duty;
    logic [PER_W-1:0] r_burst;
    logic [PER_W-1:0] r_phase;
    logic [PER_W-1:0] r_bcnt;
    logic             r_idle;
    logic             r_led;
    logic             r_done;

    logic w_wr;
    logic w_run;
    logic w_wrap;
    logic w_last;
    logic w_led_next;

    assign w_wr   = w_cfg_ok && (cfg_ch == c_idx);
    assign w_run  = r_mode[1] && !r_idle;
    assign w_wrap = (r_period == '0) || (r_phase == r_period - c_one);
    // A zero period or zero burst count ends the burst on the very first tick.
    assign w_last = (r_mode == c_mode_burst) &&
                    ((r_burst == '0) || (r_period == '0) ||
                     (w_wrap && (r_bcnt == r_burst - c_one)));
    assign w_led_next = (r_mode == c_mode_on) ||
                        (w_run && (r_period != '0) && (r_phase < r_duty));

    always_ff @(posedge clk_50 or negedge w_rst_n) begin
      if (!w_rst_n) begin
        r_mode   <= c_mode_off;
        r_period <= '0;
        r_duty   <= '0;
        r_burst  <= '0;
        r_phase  <= '0;
        r_bcnt   <= '0;
        r_idle   <= 1'b0;
        r_led    <= 1'b0;
        r_done   <= 1'b0;
      end else begin
        r_done <= 1'b0;
        r_led  <= w_led_next;
        if (w_wr) begin
          case (cfg_addr)
            c_addr_mode:   r_mode   <= cfg_wdata[1:0];
            c_addr_period: r_period <= cfg_wdata;
            c_addr_duty:   r_duty   <= cfg_wdata;
            default:       r_burst  <= cfg_wdata;
          endcase
          r_phase <= '0;
          r_bcnt  <= '0;
          r_idle  <= 1'b0;
        end else if (w_tick && w_run) begin
          if (w_last) begin
            r_phase <= '0;
            r_idle  <= 1'b1;
            r_done  <= 1'b1;
          end else if (w_wrap) begin
            r_phase <= '0;
            if (r_mode == c_mode_burst) r_bcnt <= r_bcnt + c_one;
          end else begin
            r_phase <= r_phase + c_one;
          end
        end
      end
    end

    assign led[i]        = r_led;
    assign burst_done[i] = r_done;
  end

endmodule
`default_nettype wire
